// File: rtl/spi_mstr16_if.sv
// Bus bundle between a 16-bit SPI master and its host/slave side.
// "master" is the view taken by spi_mstr16; "slave" is the view of whatever drives it.
interface spi_mstr16_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  wrt,
        input  cmd,
        input  MISO,
        output done,
        output rd_data,
        output SS_n,
        output SCLK,
        output MOSI
    );

    modport slave (
        output wrt,
        output cmd,
        output MISO,
        input  done,
        input  rd_data,
        input  SS_n,
        input  SCLK,
        input  MOSI
    );
endinterface

// File: rtl/spi_mstr16.sv
// Fixed 16-bit SPI master: SCLK = clk/32 (idle high), MSB first, samples MISO on the SCLK rise,
// shifts on the SCLK fall. done/SS_n rise 520 clks after the accepting edge.
module spi_mstr16 (
    input  logic          clk,
    input  logic          rst,
    spi_mstr16_if.master  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FRONT = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    localparam logic [4:0] DIV_IDLE = 5'b10111;
    localparam logic [4:0] DIV_RISE = 5'b01111;
    localparam logic [4:0] DIV_FALL = 5'b11111;
    localparam logic [4:0] DIV_LAST = 5'b11110;

    logic [1:0]  state_reg,   state_next;
    logic [4:0]  div_reg,     div_next;
    logic [15:0] shft_reg,    shft_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic        smpl_reg,    smpl_next;
    logic        ss_n_reg,    ss_n_next;
    logic        done_reg,    done_next;

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        shft_next    = shft_reg;
        bit_cnt_next = bit_cnt_reg;
        smpl_next    = smpl_reg;
        ss_n_next    = ss_n_reg;
        done_next    = done_reg;

        case (state_reg)
            IDLE: begin
                div_next = DIV_IDLE;
                if (bus.wrt) begin
                    shft_next    = bus.cmd;
                    ss_n_next    = 1'b0;
                    done_next    = 1'b0;
                    bit_cnt_next = 4'd0;
                    state_next   = FRONT;
                end
            end

            FRONT: begin
                div_next = div_reg + 5'd1;
                if (div_reg == DIV_RISE)
                    smpl_next = bus.MISO;
                // First SCLK fall carries no shift: cmd[15] is already on MOSI.
                if (div_reg == DIV_FALL)
                    state_next = SHIFT;
            end

            SHIFT: begin
                div_next = div_reg + 5'd1;
                if (div_reg == DIV_RISE)
                    smpl_next = bus.MISO;
                if (div_reg == DIV_FALL && bit_cnt_reg != 4'd15) begin
                    shft_next    = {shft_reg[14:0], smpl_reg};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
                // Finish one clk before the 16th fall so SCLK parks high.
                if (div_reg == DIV_LAST && bit_cnt_reg == 4'd15) begin
                    shft_next  = {shft_reg[14:0], smpl_reg};
                    ss_n_next  = 1'b1;
                    done_next  = 1'b1;
                    div_next   = DIV_IDLE;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                div_next   = DIV_IDLE;
                ss_n_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            div_reg     <= DIV_IDLE;
            shft_reg    <= 16'h0000;
            bit_cnt_reg <= 4'd0;
            smpl_reg    <= 1'b0;
            ss_n_reg    <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            shft_reg    <= shft_next;
            bit_cnt_reg <= bit_cnt_next;
            smpl_reg    <= smpl_next;
            ss_n_reg    <= ss_n_next;
            done_reg    <= done_next;
        end
    end

    assign bus.SCLK    = div_reg[4];
    assign bus.MOSI    = shft_reg[15];
    assign bus.rd_data = shft_reg;
    assign bus.SS_n    = ss_n_reg;
    assign bus.done    = done_reg;
endmodule

// File: tb/tb_spi_mstr16.sv
// Bench for spi_mstr16: per-cycle comparison against a timeline model of the frame,
// loopback / register-file sensor slave on MISO, directed scenarios plus random frames.
module tb_spi_mstr16;
    logic clk;
    logic rst;

    spi_mstr16_if bus ();

    spi_mstr16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave side: loopback, or a sensor that replays a precomputed response word.
    logic        loop_mode;
    logic [15:0] resp_cur;
    logic [4:0]  rise_cnt;
    logic [3:0]  ridx;
    logic        prev_sclk_p;

    always @(posedge clk) begin
        prev_sclk_p <= bus.SCLK;
        if (bus.SS_n)
            rise_cnt <= 5'd0;
        else if (bus.SCLK && !prev_sclk_p)
            rise_cnt <= rise_cnt + 5'd1;
    end

    always_comb begin
        ridx = 4'd15 - rise_cnt[3:0];
        if (loop_mode)
            bus.MISO = bus.MOSI;
        else if (rise_cnt < 5'd16)
            bus.MISO = resp_cur[ridx];
        else
            bus.MISO = 1'b0;
    end

    // Reference model: a frame is a 520-edge timeline after the accepting edge.
    logic        m_busy;
    int          m_t;
    logic [15:0] m_cmd, m_rx, m_rd_idle;
    logic        m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_t       <= 0;
            m_done    <= 1'b0;
            m_rd_idle <= 16'h0000;
        end else if (m_busy) begin
            if (m_t == 519) begin
                m_busy    <= 1'b0;
                m_done    <= 1'b1;
                m_rd_idle <= m_rx;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (bus.wrt) begin
            m_busy <= 1'b1;
            m_t    <= 0;
            m_cmd  <= bus.cmd;
            m_rx   <= loop_mode ? bus.cmd : resp_cur;
            m_done <= 1'b0;
        end
    end

    bit          chk_en = 1'b0;
    logic        exp_ss, exp_sclk, exp_done, prev_mosi, prev_sclk_n, prev_busy;
    logic [15:0] exp_rd;
    logic [31:0] full;
    int          nshift;
    logic        mosi_ok;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_busy) begin
                exp_ss   = 1'b1;
                exp_sclk = 1'b1;
                exp_done = m_done;
                exp_rd   = m_rd_idle;
            end else begin
                exp_ss   = 1'b0;
                exp_done = 1'b0;
                exp_sclk = (m_t < 9) ? 1'b1 : (((m_t - 9) % 32) >= 16);
                nshift   = (m_t < 41) ? 0 : ((m_t - 41) / 32 + 1);
                if (nshift > 15) nshift = 15;
                full     = {m_cmd, m_rx};
                full     = full << nshift;
                exp_rd   = full[31:16];
            end
            check("SS_n",    {31'd0, bus.SS_n}, {31'd0, exp_ss});
            check("SCLK",    {31'd0, bus.SCLK}, {31'd0, exp_sclk});
            check("done",    {31'd0, bus.done}, {31'd0, exp_done});
            check("rd_data", {16'd0, bus.rd_data}, {16'd0, exp_rd});
            check("MOSI",    {31'd0, bus.MOSI}, {31'd0, exp_rd[15]});
            if (bus.MOSI !== prev_mosi) begin
                mosi_ok = (prev_sclk_n && !bus.SCLK) || (m_busy && m_t == 0) || (prev_busy && !m_busy);
                check("mosi_edge", {31'd0, mosi_ok}, 32'd1);
            end
        end
        prev_mosi   <= bus.MOSI;
        prev_sclk_n <= bus.SCLK;
        prev_busy   <= m_busy;
    end

    // Register file behind the sensor slave.
    logic [7:0] regs [128];

    task automatic run_frame(input logic [15:0] c, input bit lp, input logic [15:0] rsp,
                             input int inj_k, input int rst_k,
                             output int rises, output int ss_low, output int done_k);
        logic last;
        loop_mode = lp;
        resp_cur  = rsp;
        bus.cmd   = c;
        bus.wrt   = 1'b1;
        @(posedge clk); #1;
        bus.wrt = 1'b0;
        bus.cmd = 16'($urandom);
        rises  = 0;
        ss_low = (bus.SS_n == 1'b0) ? 1 : 0;
        done_k = -1;
        last   = bus.SCLK;
        for (int k = 1; k <= 520; k++) begin
            if (k == inj_k) begin
                bus.wrt = 1'b1;
                bus.cmd = 16'($urandom);
            end
            if (k == rst_k) rst = 1'b1;
            @(posedge clk); #1;
            bus.wrt = 1'b0;
            if (bus.SCLK && !last) rises++;
            last = bus.SCLK;
            if (!bus.SS_n) ss_low++;
            if (bus.done && done_k < 0) done_k = k;
            if (rst) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic sensor_xfer(input logic [15:0] c, output logic [15:0] rd);
        int r, s, d;
        run_frame(c, 1'b0, {8'h00, regs[c[14:8]]}, -1, -1, r, s, d);
        rd = bus.rd_data;
        if (!c[15]) regs[c[14:8]] = c[7:0];
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int rises, ss_low, done_k, inj, rk;
        logic [15:0] rd, c, rsp;
        bit lp;

        for (int i = 0; i < 128; i++) regs[i] = 8'h00;
        regs[7'h0F] = 8'h6A;
        regs[7'h0D] = 8'hA5;
        loop_mode = 1'b1;
        resp_cur  = 16'h0000;
        bus.wrt   = 1'b0;
        bus.cmd   = 16'h0000;
        rst       = 1'b1;
        idle(3);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_SS_n",  {31'd0, bus.SS_n}, 32'd1);
        check("rst_SCLK",  {31'd0, bus.SCLK}, 32'd1);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_rd",    {16'd0, bus.rd_data}, 32'd0);
        idle(2);

        // Loopback A5C3
        run_frame(16'hA5C3, 1'b1, 16'h0000, -1, -1, rises, ss_low, done_k);
        check("loop_rd",     {16'd0, bus.rd_data}, 32'h0000A5C3);
        check("loop_rises",  rises, 32'd16);
        check("loop_sslow",  ss_low, 32'd520);
        check("loop_latency", done_k, 32'd520);
        idle(50);

        // Sensor: WHO_AM_I, then write 0x0D and read it back
        sensor_xfer(16'h8F00, rd);
        check("whoami", {24'd0, rd[7:0]}, 32'h6A);
        idle(3);
        sensor_xfer(16'h0D02, rd);
        check("wr_old", {24'd0, rd[7:0]}, 32'hA5);
        idle(3);
        sensor_xfer(16'h8D00, rd);
        check("rd_back", {24'd0, rd[7:0]}, 32'h02);
        idle(3);

        // Busy rejection
        run_frame(16'hFFFF, 1'b1, 16'h0000, 100, -1, rises, ss_low, done_k);
        check("busy_rd",      {16'd0, bus.rd_data}, 32'h0000FFFF);
        check("busy_latency", done_k, 32'd520);
        idle(40);
        check("busy_no_2nd",  {31'd0, bus.SS_n}, 32'd1);

        // Reset mid-frame, then a clean frame
        run_frame(16'h3C3C, 1'b1, 16'h0000, -1, 200, rises, ss_low, done_k);
        check("mrst_SS_n", {31'd0, bus.SS_n}, 32'd1);
        check("mrst_SCLK", {31'd0, bus.SCLK}, 32'd1);
        check("mrst_done", {31'd0, bus.done}, 32'd0);
        check("mrst_rd",   {16'd0, bus.rd_data}, 32'd0);
        idle(2);
        run_frame(16'h5A5A, 1'b1, 16'h0000, -1, -1, rises, ss_low, done_k);
        check("post_rst_rd", {16'd0, bus.rd_data}, 32'h00005A5A);

        // wrt on the done edge is ignored; the very next edge is accepted
        run_frame(16'h1357, 1'b1, 16'h0000, 520, -1, rises, ss_low, done_k);
        check("edge520_rd", {16'd0, bus.rd_data}, 32'h00001357);
        run_frame(16'h2468, 1'b0, 16'hBEEF, -1, -1, rises, ss_low, done_k);
        check("e521_rd", {16'd0, bus.rd_data}, 32'h0000BEEF);

        // Random frames
        for (int n = 0; n < 14; n++) begin
            c   = 16'($urandom);
            rsp = 16'($urandom);
            lp  = 1'($urandom_range(0, 1));
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 520)) : -1;
            rk  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 519)) : -1;
            run_frame(c, lp, rsp, inj, rk, rises, ss_low, done_k);
            if (rk < 0) check("rand_latency", done_k, 32'd520);
            idle(int'($urandom_range(0, 4)));
        end

        idle(5);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_mstr16.md
SPI_MSTR16 -- requirements
Module: spi_mstr16

Interface
REQ-001 The block SHALL have no parameters: SCLK period is fixed at 32 clk cycles, and the frame length is fixed at 16 bits.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 wrt  input  1  single-cycle request to start a 16-bit SPI transaction.
REQ-005 cmd  input  16  word to transmit MSB first; sampled only on the clk edge that accepts wrt.
REQ-006 done  output  1  transaction-complete flag, registered.
REQ-007 rd_data  output  16  word received from MISO, MSB first; valid while done=1.
REQ-008 SS_n  output  1  active-low slave select, registered.
REQ-009 SCLK  output  1  serial clock; SHALL equal bit 4 of the internal 5-bit divider (div).
REQ-010 MOSI  output  1  serial data out; SHALL equal bit 15 of the shift register.
REQ-011 MISO  input  1  serial data in from the slave (e.g. the inertial sensor).

Function
REQ-012 The block SHALL implement the states IDLE, FRONT and SHIFT.
REQ-013 In IDLE, div SHALL hold 5'b10111, so SCLK=1.
REQ-014 In IDLE, SS_n SHALL be 1.
REQ-015 On the edge (E0) where state=IDLE and wrt=1, the block SHALL set shft_reg<=cmd, div<=5'b10111, SS_n<=0, done<=0, bit_cnt<=0 and state<=FRONT.
REQ-016 In FRONT and SHIFT, div SHALL increment by 1 every clk, wrapping from 31 to 0.
REQ-017 Sampling: in any non-IDLE state, when div==5'b01111, smpl<=MISO on that edge, coincident with the registered SCLK rise.
REQ-018 FRONT: when div==5'b11111, the block SHALL go to SHIFT without shifting; the first SCLK fall is ignored because cmd[15] is already on MOSI.
REQ-019 SHIFT, when div==5'b11111 and bit_cnt<15: shft_reg<={shft_reg[14:0],smpl} and bit_cnt<=bit_cnt+1.
REQ-020 SHIFT, when div==5'b11110 and bit_cnt==15, the block SHALL in that edge:
  - perform the final shift;
  - set SS_n<=1 and done<=1;
  - set div<=5'b10111;
  - set state<=IDLE.
  SCLK SHALL therefore never fall after the 16th rise.
REQ-021 Each transaction SHALL produce exactly 16 SCLK rising edges and 16 shifts.
REQ-022 SCLK SHALL be high for 16 clks and low for 16 clks per bit.
REQ-023 Latency: done and SS_n SHALL rise on edge E520, counted from E0.
REQ-024 SS_n SHALL be low from E0 through E519.
REQ-025 done SHALL remain 1 until the next accepted wrt or rst.
REQ-026 rd_data SHALL be continuously driven from shft_reg and SHALL be stable while in IDLE.
REQ-027 wrt asserted while state!=IDLE SHALL be ignored, with no effect on cmd capture, counters or outputs.
REQ-028 wrt on the same edge that enters IDLE (E520) SHALL be ignored; a wrt on E521 or later SHALL be accepted.
REQ-029 bit_cnt SHALL be 4 bits wide and SHALL never wrap within a transaction.

Reset
REQ-030 When rst=1 at a clk edge, the block SHALL set state=IDLE, div=5'b10111 (SCLK=1), SS_n=1, done=0, shft_reg=16'h0000 (MOSI=0, rd_data=0), bit_cnt=0 and smpl=0.
REQ-031 rst SHALL take priority over wrt and over any in-progress transaction.
REQ-032 After rst deasserts, the first wrt SHALL start a clean transaction; no partial frame SHALL resume.

Verification
REQ-033 Loopback: tie MISO=MOSI, pulse wrt with cmd=16'hA5C3 -> done rises exactly 520 clks later, rd_data=16'hA5C3, 16 SCLK rises counted, SS_n low for 520 clks.
REQ-034 Sensor read: connect to the inertial sensor model after its power-on delay, send cmd=16'h8F00 -> rd_data[7:0]=8'h6A.
REQ-035 Sensor write then read: send 16'h0D02, then 16'h8D00 -> second rd_data[7:0]=8'h02, and the first rd_data[7:0]=8'hA5.
REQ-036 Busy rejection: pulse wrt with cmd=16'h1234 at E100 of a 16'hFFFF loopback -> result is 16'hFFFF at E520, with no second frame started.
REQ-037 Reset mid-frame: assert rst at E200 -> next edge gives SS_n=1, SCLK=1, done=0, rd_data=0; a subsequent loopback of 16'h5A5A completes correctly.
REQ-038 Idle checks: SCLK=1 and SS_n=1 whenever state=IDLE; MOSI changes only on edges where SCLK falls, or at E0.
